// File: rtl/seq_pkg.sv
// Shared constants, state and instruction-class types for the
// multicycle datapath sequencer.
package seq_pkg;

   localparam int OP_ADD  = 0;
   localparam int OP_SUB  = 1;
   localparam int OP_AND  = 2;
   localparam int OP_OR   = 3;
   localparam int OP_SHR  = 4;
   localparam int OP_SHL  = 5;
   localparam int OP_ROR  = 6;
   localparam int OP_ROL  = 7;
   localparam int OP_ADDI = 8;
   localparam int OP_ANDI = 9;
   localparam int OP_ORI  = 10;
   localparam int OP_LD   = 11;
   localparam int OP_ST   = 12;
   localparam int OP_MUL  = 13;
   localparam int OP_DIV  = 14;
   localparam int OP_NEG  = 15;
   localparam int OP_NOT  = 16;
   localparam int OP_IN   = 17;
   localparam int OP_OUT  = 18;
   localparam int OP_NOP  = 19;
   localparam int OP_HALT = 20;

   localparam logic [3:0] ALU_ADD = 4'd0;
   localparam logic [3:0] ALU_SUB = 4'd1;
   localparam logic [3:0] ALU_AND = 4'd2;
   localparam logic [3:0] ALU_OR  = 4'd3;
   localparam logic [3:0] ALU_SHR = 4'd4;
   localparam logic [3:0] ALU_SHL = 4'd5;
   localparam logic [3:0] ALU_ROR = 4'd6;
   localparam logic [3:0] ALU_ROL = 4'd7;
   localparam logic [3:0] ALU_MUL = 4'd8;
   localparam logic [3:0] ALU_DIV = 4'd9;
   localparam logic [3:0] ALU_NEG = 4'd10;
   localparam logic [3:0] ALU_NOT = 4'd11;
   localparam logic [3:0] ALU_INC = 4'd12;

   localparam int EN_HI      = 16;
   localparam int EN_LO      = 17;
   localparam int EN_Z       = 18;
   localparam int EN_Y       = 19;
   localparam int EN_PC      = 20;
   localparam int EN_MDR     = 21;
   localparam int EN_INPORT  = 22;
   localparam int EN_IR      = 23;
   localparam int EN_MAR     = 25;
   localparam int EN_OUTPORT = 26;

   localparam int BS_HI     = 16;
   localparam int BS_LO     = 17;
   localparam int BS_ZHI    = 18;
   localparam int BS_ZLO    = 19;
   localparam int BS_PC     = 20;
   localparam int BS_MDR    = 21;
   localparam int BS_INPORT = 22;
   localparam int BS_C      = 23;

   typedef enum logic [4:0] {
      S_IDLE,
      S_FETCH0,
      S_FETCH1,
      S_FETCH2,
      S_EX0,
      S_EX1,
      S_EX2,
      S_EX3,
      S_EX4,
      S_HALTED
   } state_t;

   typedef enum logic [3:0] {
      CL_RTYPE,
      CL_IMM,
      CL_UNARY,
      CL_MULDIV,
      CL_LD,
      CL_ST,
      CL_IN,
      CL_OUT,
      CL_NOP,
      CL_HALT,
      CL_ILL
   } iclass_t;

   function automatic logic [31:0] bit32(input int idx);
      return 32'd1 << idx;
   endfunction

endpackage

// File: rtl/datapath_sequencer_if.sv
// Control bundle between the sequencer (master) and the datapath
// plus memory (slave).
interface datapath_sequencer_if;

   logic        run;
   logic [31:0] ir;
   logic        mem_ready;
   logic [31:0] enable;
   logic [31:0] busSelect;
   logic [3:0]  Control_Signals;
   logic        MD_Read;
   logic        mem_read;
   logic        mem_write;
   logic        halted;
   logic        illegal;
   logic [4:0]  state;

   modport master (
      input  run,
      input  ir,
      input  mem_ready,
      output enable,
      output busSelect,
      output Control_Signals,
      output MD_Read,
      output mem_read,
      output mem_write,
      output halted,
      output illegal,
      output state
   );

   modport slave (
      output run,
      output ir,
      output mem_ready,
      input  enable,
      input  busSelect,
      input  Control_Signals,
      input  MD_Read,
      input  mem_read,
      input  mem_write,
      input  halted,
      input  illegal,
      input  state
   );

endinterface

// File: rtl/seq_decode.sv
// Opcode to instruction-class and ALU-code map; purely combinational.
module seq_decode
   import seq_pkg::*;
#(
   parameter int OPW = 5
) (
   input  logic [OPW-1:0] i_op,
   output iclass_t        o_class,
   output logic [3:0]     o_alu
);

   always_comb begin
      o_class = CL_ILL;
      o_alu   = ALU_ADD;
      unique case (int'(i_op))
         OP_ADD, OP_SUB, OP_AND, OP_OR,
         OP_SHR, OP_SHL, OP_ROR, OP_ROL: begin
            o_class = CL_RTYPE;
            o_alu   = 4'(i_op);
         end
         OP_ADDI: begin
            o_class = CL_IMM;
            o_alu   = ALU_ADD;
         end
         OP_ANDI: begin
            o_class = CL_IMM;
            o_alu   = ALU_AND;
         end
         OP_ORI: begin
            o_class = CL_IMM;
            o_alu   = ALU_OR;
         end
         OP_LD:   o_class = CL_LD;
         OP_ST:   o_class = CL_ST;
         OP_MUL: begin
            o_class = CL_MULDIV;
            o_alu   = ALU_MUL;
         end
         OP_DIV: begin
            o_class = CL_MULDIV;
            o_alu   = ALU_DIV;
         end
         OP_NEG: begin
            o_class = CL_UNARY;
            o_alu   = ALU_NEG;
         end
         OP_NOT: begin
            o_class = CL_UNARY;
            o_alu   = ALU_NOT;
         end
         OP_IN:   o_class = CL_IN;
         OP_OUT:  o_class = CL_OUT;
         OP_NOP:  o_class = CL_NOP;
         OP_HALT: o_class = CL_HALT;
         default: o_class = CL_ILL;
      endcase
   end

endmodule

// File: rtl/datapath_sequencer.sv
// Multicycle hardwired control unit: fetch, decode-in-EX0 and execute
// sequencing for the 32-bit bus datapath.
module datapath_sequencer
   import seq_pkg::*;
#(
   parameter bit RUN_ON_RESET = 1'b1,
   parameter int OPW          = 5,
   parameter int RIDX         = 4
) (
   input logic                  clk,
   input logic                  clr,
   datapath_sequencer_if.master bus
);

   state_t          r_state;
   state_t          w_next;
   iclass_t         w_cls;
   logic [3:0]      w_alu;
   logic [RIDX-1:0] w_ra;
   logic [RIDX-1:0] w_rb;
   logic [RIDX-1:0] w_rc;
   logic [31:0]     w_ra_oh;
   logic [31:0]     w_rb_oh;
   logic [31:0]     w_rc_oh;
   logic [31:0]     w_en;
   logic [31:0]     w_bs;
   logic [3:0]      w_cs;
   logic            w_mdr;
   logic            w_rd;
   logic            w_wr;
   logic            w_hlt;
   logic            w_ill;
   logic            w_unused;

   assign w_ra = bus.ir[31-OPW -: RIDX];
   assign w_rb = bus.ir[31-OPW-RIDX -: RIDX];
   assign w_rc = bus.ir[31-OPW-2*RIDX -: RIDX];
   assign w_ra_oh = 32'd1 << w_ra;
   assign w_rb_oh = 32'd1 << w_rb;
   assign w_rc_oh = 32'd1 << w_rc;

   // The constant field is sign-extended by the datapath, not here.
   assign w_unused = &{1'b0, bus.ir[31-OPW-3*RIDX:0]};

   seq_decode #(
      .OPW (OPW)
   ) u_decode (
      .i_op    (bus.ir[31 -: OPW]),
      .o_class (w_cls),
      .o_alu   (w_alu)
   );

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         r_state <= RUN_ON_RESET ? S_FETCH0 : S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      w_en   = '0;
      w_bs   = '0;
      w_cs   = ALU_ADD;
      w_mdr  = 1'b0;
      w_rd   = 1'b0;
      w_wr   = 1'b0;
      w_hlt  = 1'b0;
      w_ill  = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (bus.run) w_next = S_FETCH0;
         end
         S_HALTED: begin
            w_hlt = 1'b1;
            if (bus.run) w_next = S_FETCH0;
         end
         S_FETCH0: begin
            w_bs   = bit32(BS_PC);
            w_en   = bit32(EN_MAR) | bit32(EN_Z);
            w_cs   = ALU_INC;
            w_next = S_FETCH1;
         end
         S_FETCH1: begin
            w_bs  = bit32(BS_ZLO);
            w_en  = bit32(EN_PC) | bit32(EN_MDR);
            w_rd  = 1'b1;
            w_mdr = 1'b1;
            if (bus.mem_ready) w_next = S_FETCH2;
         end
         S_FETCH2: begin
            w_bs   = bit32(BS_MDR);
            w_en   = bit32(EN_IR);
            w_next = S_EX0;
         end
         // IR is first visible here, so even NOP spends one EX0 cycle.
         S_EX0: begin
            unique case (w_cls)
               CL_RTYPE, CL_IMM, CL_LD, CL_ST: begin
                  w_bs   = w_rb_oh;
                  w_en   = bit32(EN_Y);
                  w_next = S_EX1;
               end
               CL_UNARY: begin
                  w_bs   = w_rb_oh;
                  w_cs   = w_alu;
                  w_en   = bit32(EN_Z);
                  w_next = S_EX1;
               end
               CL_MULDIV: begin
                  w_bs   = w_ra_oh;
                  w_en   = bit32(EN_Y);
                  w_next = S_EX1;
               end
               CL_IN: begin
                  w_bs   = bit32(BS_INPORT);
                  w_en   = w_ra_oh;
                  w_next = S_FETCH0;
               end
               CL_OUT: begin
                  w_bs   = w_ra_oh;
                  w_en   = bit32(EN_OUTPORT);
                  w_next = S_FETCH0;
               end
               CL_NOP:  w_next = S_FETCH0;
               CL_HALT: w_next = S_HALTED;
               default: begin
                  w_ill  = 1'b1;
                  w_next = S_FETCH0;
               end
            endcase
         end
         S_EX1: begin
            unique case (w_cls)
               CL_RTYPE: begin
                  w_bs   = w_rc_oh;
                  w_cs   = w_alu;
                  w_en   = bit32(EN_Z);
                  w_next = S_EX2;
               end
               CL_IMM, CL_LD, CL_ST: begin
                  w_bs   = bit32(BS_C);
                  w_cs   = w_alu;
                  w_en   = bit32(EN_Z);
                  w_next = S_EX2;
               end
               CL_UNARY: begin
                  w_bs   = bit32(BS_ZLO);
                  w_en   = w_ra_oh;
                  w_next = S_FETCH0;
               end
               CL_MULDIV: begin
                  w_bs   = w_rb_oh;
                  w_cs   = w_alu;
                  w_en   = bit32(EN_Z);
                  w_next = S_EX2;
               end
               default: w_next = S_FETCH0;
            endcase
         end
         S_EX2: begin
            unique case (w_cls)
               CL_RTYPE, CL_IMM: begin
                  w_bs   = bit32(BS_ZLO);
                  w_en   = w_ra_oh;
                  w_next = S_FETCH0;
               end
               CL_LD, CL_ST: begin
                  w_bs   = bit32(BS_ZLO);
                  w_en   = bit32(EN_MAR);
                  w_next = S_EX3;
               end
               CL_MULDIV: begin
                  w_bs   = bit32(BS_ZLO);
                  w_en   = bit32(EN_LO);
                  w_next = S_EX3;
               end
               default: w_next = S_FETCH0;
            endcase
         end
         S_EX3: begin
            unique case (w_cls)
               CL_MULDIV: begin
                  w_bs   = bit32(BS_ZHI);
                  w_en   = bit32(EN_HI);
                  w_next = S_FETCH0;
               end
               CL_LD: begin
                  w_rd  = 1'b1;
                  w_mdr = 1'b1;
                  w_en  = bit32(EN_MDR);
                  if (bus.mem_ready) w_next = S_EX4;
               end
               CL_ST: begin
                  w_bs   = w_ra_oh;
                  w_en   = bit32(EN_MDR);
                  w_next = S_EX4;
               end
               default: w_next = S_FETCH0;
            endcase
         end
         S_EX4: begin
            unique case (w_cls)
               CL_LD: begin
                  w_bs   = bit32(BS_MDR);
                  w_en   = w_ra_oh;
                  w_next = S_FETCH0;
               end
               CL_ST: begin
                  w_wr = 1'b1;
                  if (bus.mem_ready) w_next = S_FETCH0;
               end
               default: w_next = S_FETCH0;
            endcase
         end
         default: w_next = S_FETCH0;
      endcase
   end

   // Outputs are forced low for the whole time clr is asserted.
   assign bus.enable          = clr ? w_en : 32'd0;
   assign bus.busSelect       = clr ? w_bs : 32'd0;
   assign bus.Control_Signals = clr ? w_cs : 4'd0;
   assign bus.MD_Read         = clr & w_mdr;
   assign bus.mem_read        = clr & w_rd;
   assign bus.mem_write       = clr & w_wr;
   assign bus.halted          = clr & w_hlt;
   assign bus.illegal         = clr & w_ill;
   assign bus.state           = clr ? 5'(r_state) : 5'd0;

endmodule

// File: doc/datapath_sequencer.md
Name: datapath_sequencer

Overview:
- Multicycle hardwired control unit for the 32-bit bus datapath.
- Drives the datapath's register-enable vector, one-hot bus-source select, ALU control nibble and MDR read-select.
- Sequences fetch, decode and execute for the Phase-2 instruction subset.
- Handshakes with a word-addressed memory through req/ready and observes the instruction register.

Parameters:
- RUN_ON_RESET, 1, 1: leave reset straight into FETCH0. 0: leave reset into IDLE and wait for run.
- OPW, 5, opcode field width, IR[31:27].
- RIDX, 4, register index width: Ra=IR[26:23], Rb=IR[22:19], Rc=IR[18:15].

Ports:
- clk  in  1  system clock. One clock.
- clr  in  1  reset, asynchronous, active-low.
- run  in  1  one-cycle pulse; leaves IDLE or HALTED and enters FETCH0.
- ir  in  32  IR register contents from the datapath.
- mem_ready  in  1  memory has completed the current read or write.
- enable  out  32  register load enables: 0-15 R0-R15, 16 HI, 17 LO, 18 Z, 19 Y, 20 PC, 21 MDR, 22 INPORT, 23 IR, 25 MAR, 26 OUTPORT. Bits 24 and 27-31 are always 0.
- busSelect  out  32  one-hot bus source: 0-15 R0-R15, 16 HI, 17 LO, 18 ZHI, 19 ZLO, 20 PC, 21 MDR, 22 INPORT, 23 C sign-extended. All-zero when no source drives the bus.
- Control_Signals  out  4  ALU opcode.
- MD_Read  out  1  MDR input select: 1 = memory data, 0 = bus.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- halted  out  1  high while in HALTED.
- illegal  out  1  one-cycle pulse on an undefined opcode.
- state  out  5  current state encoding, for debug.

Behaviour:
- Moore machine. Every output is a combinational decode of the state register and the ir input only. No output depends on mem_ready or run.
- Datapath registers capture on the clk edge that ends the state in which their enable is high.
- Reset (clr=0, async): state <= FETCH0 or IDLE per RUN_ON_RESET. While clr=0 all outputs are 0, including halted and illegal. Reset mid-instruction abandons the instruction; no partial-state recovery.
- Unlisted outputs are 0 in every state. "Ra" etc. mean the one-hot bit selected by that IR field.
- FETCH0: busSelect[PC], enable[MAR], Control_Signals=INC, enable[Z].
- FETCH1: busSelect[ZLO], enable[PC], mem_read, MD_Read, enable[MDR]. Stays in FETCH1 until mem_ready=1 is sampled. Repeated PC/MDR loads while waiting are harmless.
- FETCH2: busSelect[MDR], enable[IR].
- DECODE is folded into EX0; the ir input is valid from EX0 onward.
- R-type (ADD SUB AND OR SHR SHL ROR ROL):
  - EX0: Rb out, Yin.
  - EX1: Rc out, ALU op, Zin.
  - EX2: ZLO out, Ra in.
- Immediate (ADDI ANDI ORI): as R-type, except EX1 uses busSelect[23] in place of Rc.
- NEG, NOT:
  - EX0: Rb out, ALU op, Zin.
  - EX1: ZLO out, Ra in.
- MUL, DIV:
  - EX0: Ra out, Yin.
  - EX1: Rb out, op, Zin.
  - EX2: ZLO out, LO in.
  - EX3: ZHI out, HI in.
- LD:
  - EX0: Rb out, Yin.
  - EX1: C out, ADD, Zin.
  - EX2: ZLO out, MAR in.
  - EX3: mem_read, MD_Read, MDR in; waits for mem_ready.
  - EX4: MDR out, Ra in.
- ST:
  - EX0-EX2 as LD.
  - EX3: Ra out, MDR in (MD_Read=0).
  - EX4: mem_write; waits for mem_ready.
- IN: EX0 INPORT out, Ra in.
- OUT: EX0 Ra out, OUTPORT in.
- NOP: returns to FETCH0 after FETCH2.
- HALT: enters HALTED.
- Last EX state of each instruction goes to FETCH0.
- HALTED/IDLE: all outputs 0 (except halted=1 in HALTED). Leave on run=1.
- Undefined opcode: illegal=1 during EX0, then FETCH0.
- Cycle counts with mem_ready tied high: R-type 6, MUL 7, LD 8, ST 8. Each wait cycle adds 1.
- Exactly one busSelect bit is high, or none. Never two.

Decomposition:
- Package seq_pkg:
  - Opcode constants: ADD=0, SUB=1, AND=2, OR=3, SHR=4, SHL=5, ROR=6, ROL=7, ADDI=8, ANDI=9, ORI=10, LD=11, ST=12, MUL=13, DIV=14, NEG=15, NOT=16, IN=17, OUT=18, NOP=19, HALT=20.
  - ALU codes: ADD=0, SUB=1, AND=2, OR=3, SHR=4, SHL=5, ROR=6, ROL=7, MUL=8, DIV=9, NEG=10, NOT=11, INC=12.
  - Enable and bus-select index constants.
  - State enum.
- One sub-module, seq_decode: combinational map opcode -> instruction class and ALU code.

Test Plan:
1. mem_ready=1, ir=ADD R1,R2,R3 (0x00918000) -> cycle-exact check:
   - FETCH0: busSelect=0x100000, enable=0x2040000.
   - FETCH1: busSelect=0x80000, enable=0x300000.
   - FETCH2: busSelect=0x200000, enable=0x800000.
   - EX0: busSelect=0x4, enable=0x80000.
   - EX1: busSelect=0x8, enable=0x40000, Control_Signals=0.
   - EX2: busSelect=0x80000, enable=0x2.
   - Next FETCH0 on cycle 6.
2. mem_ready held low 3 cycles in FETCH1 -> FETCH1 held 4 cycles, mem_read=1 throughout, FETCH2 on the following cycle.
3. MUL R4,R5 -> Control_Signals=8 in EX1; LO enable (0x20000) in EX2, then HI enable (0x10000) in EX3; 7 cycles total.
4. LD R1, C=0x55 -> EX1 busSelect=0x800000; EX3 mem_read=1 and MD_Read=1; EX4 enable=0x2; 8 cycles total.
5. HALT -> halted=1; outputs stay 0 for 10 cycles; run pulse -> FETCH0 next cycle, halted=0.
6. Two cases:
   - Opcode 31 -> illegal pulses 1 cycle, then FETCH0.
   - clr low in EX1 -> all outputs 0 immediately (async); after release, FETCH0.
